// File: rtl/bitrev_pkg.sv
// Shared definitions for the bit-reversal reorder buffer.
//   MAX_LOG_N : largest supported log2 frame length
//   bitrev()  : reverses the low log_n bits of an index; bits above log_n are ignored
package bitrev_pkg;

    localparam int unsigned MAX_LOG_N = 12;

    // Result is returned as a plain integer so callers can size-cast it to
    // their own address width without leaving unused bits behind.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log_n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_LOG_N; i++) begin
            if (i < log_n) begin
                r = (r << 1) | ((idx >> i) & 32'd1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reorder_bank.sv
// One N x DATA_W storage bank: synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module reorder_bank #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LOG_N  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LOG_N-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LOG_N-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned N = 1 << LOG_N;

    logic [DATA_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong frame buffer that reorders N-word frames into bit-reversed order
// (or passes them through in natural order), one word per cycle each side.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_bitrev          : read-order mode, sampled on the first word of a frame
//   in_valid/in_ready   : input handshake, in_data in natural order
//   out_valid/out_ready : output handshake, out_data reordered
//   out_last            : marks the final word of each output frame
module bitrev_reorder_buffer
    import bitrev_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LOG_N  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_bitrev,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    logic [1:0]       full_q;
    logic [1:0]       mode_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [LOG_N-1:0] wr_cnt_q;
    logic [LOG_N-1:0] rd_cnt_q;

    logic             in_fire;
    logic             out_fire;
    logic             wr_last;
    logic [LOG_N-1:0] rd_addr;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // A bank being written is never full and a bank being read is always
    // full, so the write and read sides can never target the same flag.
    assign in_ready  = ~full_q[wr_ptr_q];
    assign out_valid = full_q[rd_ptr_q];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign wr_last   = (wr_cnt_q == '1);
    assign out_last  = out_valid & (rd_cnt_q == '1);

    always_comb begin
        rd_addr = rd_cnt_q;
        if (mode_q[rd_ptr_q]) begin
            rd_addr = LOG_N'(bitrev(32'(rd_cnt_q), LOG_N));
        end
    end

    assign out_data = rd_ptr_q ? rdata1 : rdata0;

    reorder_bank #(
        .DATA_W (DATA_W),
        .LOG_N  (LOG_N)
    ) u_bank0 (
        .clk   (clk),
        .we    (in_fire & ~wr_ptr_q),
        .waddr (wr_cnt_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    reorder_bank #(
        .DATA_W (DATA_W),
        .LOG_N  (LOG_N)
    ) u_bank1 (
        .clk   (clk),
        .we    (in_fire & wr_ptr_q),
        .waddr (wr_cnt_q),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            mode_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_cnt_q == '0) begin
                    mode_q[wr_ptr_q] <= cfg_bitrev;
                end
                if (wr_last) begin
                    full_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q         <= ~wr_ptr_q;
                    wr_cnt_q         <= '0;
                end
            end
            if (out_fire) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
                if (out_last) begin
                    full_q[rd_ptr_q] <= 1'b0;
                    rd_ptr_q         <= ~rd_ptr_q;
                    rd_cnt_q         <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Self-checking bench for bitrev_reorder_buffer (LOG_N=3, DATA_W=16).
// Reference model: frames collected in arrays, reordered with integer
// arithmetic into an expected-output queue; bank occupancy tracked as a
// count of complete undelivered frames.
module tb_bitrev_reorder_buffer;

    localparam int unsigned DW = 16;
    localparam int unsigned LN = 3;
    localparam int         NW = 1 << LN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_bitrev;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    bitrev_reorder_buffer #(
        .DATA_W (DW),
        .LOG_N  (LN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_bitrev (cfg_bitrev),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] frame [NW];
    int            wr_k    = 0;
    int            rd_j    = 0;
    int            pending = 0;
    logic          cur_mode = 1'b0;
    bit            capture  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Read position j of a frame maps to input word whose index is j's bits reversed.
    function automatic int rev_index(input int j);
        int r;
        r = 0;
        for (int b = 0; b < int'(LN); b++) r = r * 2 + ((j >> b) % 2);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        wr_k     = 0;
        rd_j     = 0;
        pending  = 0;
        cur_mode = 1'b0;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model.
    task automatic tick(input logic iv, input logic [DW-1:0] d, input logic c,
                        input logic ordy, output logic accepted);
        logic exp_ready;
        logic exp_valid;
        in_valid   = iv;
        in_data    = d;
        cfg_bitrev = c;
        out_ready  = ordy;
        @(negedge clk);
        exp_ready = (pending < 2);
        exp_valid = (pending > 0);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            check("out_last", 32'(out_last), 32'(rd_j == NW - 1));
        end else begin
            check("out_last_idle", 32'(out_last), 32'd0);
        end
        accepted = iv && exp_ready;
        if (exp_valid && ordy) begin
            if (capture) got_q.push_back(out_data);
            void'(exp_q.pop_front());
            rd_j++;
            if (rd_j == NW) begin
                rd_j = 0;
                pending--;
            end
        end
        if (accepted) begin
            if (wr_k == 0) cur_mode = c;
            frame[wr_k] = d;
            wr_k++;
            if (wr_k == NW) begin
                for (int j = 0; j < NW; j++)
                    exp_q.push_back(cur_mode ? frame[rev_index(j)] : frame[j]);
                wr_k = 0;
                pending++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer count sequential words, holding each until accepted. Mode flips
    // to ~c from word index toggle_at onward (toggle_at < 0: never).
    task automatic push_words(input int count, input int base, input logic c,
                              input int toggle_at, input logic ordy, output int cycles);
        int   idx;
        logic cc;
        logic acc;
        idx    = 0;
        cycles = 0;
        while (idx < count && cycles < 200) begin
            cc = (toggle_at >= 0 && idx >= toggle_at) ? ~c : c;
            tick(1'b1, DW'(base + idx), cc, ordy, acc);
            cycles++;
            if (acc) idx++;
        end
        if (idx < count) check("push_timeout", 32'(idx), 32'(count));
    endtask

    task automatic drain();
        int   budget;
        logic acc;
        budget = 0;
        while (pending > 0 && budget < 100) begin
            tick(1'b0, '0, 1'b0, 1'b1, acc);
            budget++;
        end
        if (pending > 0) check("drain_timeout", 32'(pending), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   n_acc;
        logic acc;
        int   exp_rev [NW] = '{0, 4, 2, 6, 1, 5, 3, 7};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_bitrev = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Bit-reversed frame 0..7
        capture = 1'b1;
        got_q.delete();
        push_words(NW, 0, 1'b1, -1, 1'b1, cyc);
        drain();
        capture = 1'b0;
        check("rev_count", 32'(got_q.size()), 32'(NW));
        for (int j = 0; j < NW && j < got_q.size(); j++)
            check("rev_order", 32'(got_q[j]), 32'(exp_rev[j]));

        // Natural-order frame 0..7
        capture = 1'b1;
        got_q.delete();
        push_words(NW, 0, 1'b0, -1, 1'b1, cyc);
        drain();
        capture = 1'b0;
        check("nat_count", 32'(got_q.size()), 32'(NW));
        for (int j = 0; j < NW && j < got_q.size(); j++)
            check("nat_order", 32'(got_q[j]), 32'(j));

        // Three back-to-back frames: one word per cycle, no input stalls
        push_words(3 * NW, 16'h100, 1'b1, -1, 1'b1, cyc);
        check("stream_cycles", 32'(cyc), 32'(3 * NW));
        drain();

        // Output stalled: exactly two frames fit, then in_ready stays low
        push_words(2 * NW, 16'h200, 1'b1, -1, 1'b0, cyc);
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 16'h2ff, 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        check("stall_accepts", 32'(n_acc), 32'd0);
        drain();

        // Mode change mid-frame is ignored
        push_words(NW, 16'h300, 1'b1, 3, 1'b1, cyc);
        drain();
        push_words(NW, 16'h400, 1'b0, 3, 1'b1, cyc);
        drain();

        // Reset after 5 of 8 words, then a clean frame
        push_words(5, 16'h500, 1'b1, -1, 1'b1, cyc);
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_words(NW, 16'h600, 1'b1, -1, 1'b1, cyc);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick(($urandom % 4) != 0, DW'($urandom), 1'($urandom), ($urandom % 3) != 0, acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
